// File: rtl/mult_seq_unit_if.sv
// Handshake and operand/result bundle between EX-stage control and the iterative multiplier.
// The master drives operands and start; the slave (multiplier) returns busy/done/product.
interface mult_seq_unit_if #(
  parameter int WIDTH = 32
);
  logic                   start;
  logic                   is_signed;
  logic [WIDTH-1:0]       op_a;
  logic [WIDTH-1:0]       op_b;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     mult_ans;

  modport master (
    output start, is_signed, op_a, op_b,
    input  busy, done, mult_ans
  );

  modport slave (
    input  start, is_signed, op_a, op_b,
    output busy, done, mult_ans
  );
endinterface

// File: rtl/mult_seq_unit.sv
// Iterative shift-add multiplier (MULT/MULTU), one multiplier bit per cycle.
// Signed operands are reduced to magnitudes and the sign is reapplied to the final product.
module mult_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  mult_seq_unit_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic [WIDTH-1:0]       mag_a_r;
  logic [WIDTH-1:0]       mag_b_r;
  logic                   neg_r;
  logic [2*WIDTH-1:0]     acc_r;
  logic [CW-1:0]          cnt_r;
  logic                   busy_r;
  logic                   done_r;
  logic [2*WIDTH-1:0]     mult_ans_r;

  // Magnitude of an operand; the most negative value maps onto itself as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v, input logic neg);
    if (neg) begin
      return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CW'(WIDTH - 1)) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Operand capture, shift-add iteration and result publication.
  always_ff @(posedge clk) begin
    if (reset) begin
      mag_a_r    <= {WIDTH{1'b0}};
      mag_b_r    <= {WIDTH{1'b0}};
      neg_r      <= 1'b0;
      acc_r      <= {(2*WIDTH){1'b0}};
      cnt_r      <= {CW{1'b0}};
      mult_ans_r <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            mag_a_r <= magnitude(bus.op_a, bus.is_signed);
            mag_b_r <= magnitude(bus.op_b, bus.is_signed);
            neg_r   <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
            acc_r   <= {(2*WIDTH){1'b0}};
            cnt_r   <= {CW{1'b0}};
          end
        end
        RUN: begin
          if (mag_b_r[0]) begin
            acc_r <= acc_r + ({{WIDTH{1'b0}}, mag_a_r} << cnt_r);
          end
          mag_b_r <= mag_b_r >> 1;
          cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
        DONE: begin
          mult_ans_r <= apply_sign(acc_r, neg_r);
        end
        default: begin
          acc_r <= {(2*WIDTH){1'b0}};
        end
      endcase
    end
  end

  // Registered handshake: busy tracks the upcoming state, done follows the DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= (state_r == DONE);
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.mult_ans = mult_ans_r;

endmodule

// File: tb/tb_mult_seq_unit.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, random vs arithmetic model.
module tb_mult_seq_unit;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mult_seq_unit_if #(.WIDTH(W)) bus();
  mult_seq_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%016h expected=0x%016h", name, got, exp);
    end
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end else begin
      ua = {32'h0, a};
      ub = {32'h0, b};
      return ua * ub;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and wait for done; lat counts edges after the accepting edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [63:0] res, output int lat, output logic busy_ok);
    bus.start     = 1'b1;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.is_signed = s;
    tick();
    bus.start = 1'b0;
    busy_ok   = (bus.busy === 1'b1);
    lat       = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
      if (bus.done !== 1'b1 && bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    if (bus.busy !== 1'b0) busy_ok = 1'b0;
    res = bus.mult_ans;
  endtask

  initial begin
    logic [63:0] res;
    logic [63:0] held;
    int          lat;
    logic        bok;
    int          done_cnt;
    logic [31:0] ra, rb;
    logic        rs;

    vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001};
    vecs[1] = '{32'hFFFFFFFD, 32'h00000005, 1'b1, 64'hFFFFFFFF_FFFFFFF1};
    vecs[2] = '{32'hFFFFFFFD, 32'h00000005, 1'b0, 64'h00000004_FFFFFFF1};
    vecs[3] = '{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000};
    vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF_80000000};
    vecs[5] = '{32'h00000000, 32'h00001234, 1'b0, 64'h00000000_00000000};
    vecs[6] = '{32'h00000007, 32'h00000009, 1'b1, 64'h00000000_0000003F};
    vecs[7] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFF_80000001};

    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.op_a      = 32'h0;
    bus.op_b      = 32'h0;
    tick();
    tick();
    chk("reset_busy", {63'h0, bus.busy}, 64'h0);
    chk("reset_done", {63'h0, bus.done}, 64'h0);
    chk("reset_ans", bus.mult_ans, 64'h0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, res, lat, bok);
      chk($sformatf("vec%0d_ans", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd33);
      chk($sformatf("vec%0d_busy", i), {63'h0, bok}, 64'h1);
      tick();
      chk($sformatf("vec%0d_done_pulse", i), {63'h0, bus.done}, 64'h0);
    end

    // Result stays stable while idle.
    held = bus.mult_ans;
    repeat (5) tick();
    chk("idle_hold", bus.mult_ans, 64'hFFFFFFFF_80000001);

    // Reset in cycle 10 of a 7*9 run aborts it.
    bus.start = 1'b1; bus.op_a = 32'd7; bus.op_b = 32'd9; bus.is_signed = 1'b0;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrun_reset_busy", {63'h0, bus.busy}, 64'h0);
    chk("midrun_reset_done", {63'h0, bus.done}, 64'h0);
    chk("midrun_reset_ans", bus.mult_ans, 64'h0);
    tick();
    run_op(32'd7, 32'd9, 1'b0, res, lat, bok);
    chk("after_reset_ans", res, 64'd63);
    chk("after_reset_lat", 64'(lat), 64'd33);

    // Starts during RUN are ignored; done pulses once.
    tick();
    bus.start = 1'b1; bus.op_a = 32'h1234; bus.op_b = 32'h10; bus.is_signed = 1'b0;
    tick();
    done_cnt = 0;
    res      = 64'h0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 5 || c == 20) begin
        bus.start = 1'b1; bus.op_a = 32'hFFFF; bus.op_b = 32'hABCD; bus.is_signed = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      if (bus.done === 1'b1) begin
        done_cnt++;
        res = bus.mult_ans;
      end
    end
    chk("ignore_start_ans", res, 64'h12340);
    chk("ignore_start_done_cnt", 64'(done_cnt), 64'd1);

    // Back-to-back: second start in the done cycle; 42 held until the second done.
    run_op(32'd6, 32'd7, 1'b0, res, lat, bok);
    chk("b2b_first_ans", res, 64'd42);
    bus.start = 1'b1; bus.op_a = 32'h0; bus.op_b = 32'h1234; bus.is_signed = 1'b0;
    tick();
    bus.start = 1'b0;
    chk("b2b_accept_busy", {63'h0, bus.busy}, 64'h1);
    bok = 1'b1;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.mult_ans !== 64'd42) bok = 1'b0;
      tick();
      lat++;
    end
    chk("b2b_hold_42", {63'h0, bok}, 64'h1);
    chk("b2b_second_lat", 64'(lat), 64'd33);
    chk("b2b_second_ans", bus.mult_ans, 64'h0);
    tick();

    // Random operands against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom();
      rb = $urandom();
      rs = 1'($urandom_range(1, 0));
      if (i % 6 == 0) ra = 32'h80000000;
      if (i % 7 == 1) rb = 32'hFFFFFFFF;
      run_op(ra, rb, rs, res, lat, bok);
      chk($sformatf("rand%0d_%08h_%08h_s%0d", i, ra, rb, rs), res, model(ra, rb, rs));
      chk($sformatf("rand%0d_lat", i), 64'(lat), 64'd33);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
